// File: rtl/piso_serializer.sv
// Parallel-in/serial-out shift register with a valid/ready load handshake,
// shift-enable bit-rate control, selectable bit order and frame status outputs.
module piso_serializer #(
  parameter int   WIDTH      = 8,
  parameter bit   LSB_FIRST  = 1'b0,
  parameter logic IDLE_LEVEL = 1'b0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     load_valid,
  output logic                     load_ready,
  input  logic [WIDTH-1:0]         parallel_in,
  input  logic                     shift_en,
  output logic                     serial_out,
  output logic                     busy,
  output logic [$clog2(WIDTH)-1:0] bit_idx,
  output logic                     done
);

  localparam int IDX_W = $clog2(WIDTH);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

  // Handshake: a frame transfers on a rising edge where load_valid && load_ready;
  // the source holds parallel_in and load_valid stable until that edge.
  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   shreg_q, shreg_d;
  logic [IDX_W-1:0]   bit_idx_q, bit_idx_d;
  logic               done_q, done_d;
  logic               last;
  logic               out_bit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      shreg_q   <= '0;
      bit_idx_q <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      bit_idx_q <= bit_idx_d;
      done_q    <= done_d;
    end
  end

  // The last bit is consumed on this edge; the next frame may load in the same cycle.
  assign last = (state_q == ST_SHIFT) && (bit_idx_q == LAST_IDX) && shift_en;

  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    bit_idx_d = bit_idx_q;
    done_d    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (load_valid) begin
          shreg_d   = parallel_in;
          bit_idx_d = '0;
          state_d   = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (last) begin
          done_d = 1'b1;
          if (load_valid) begin
            shreg_d   = parallel_in;
            bit_idx_d = '0;
          end else begin
            state_d = ST_IDLE;
          end
        end else if (shift_en) begin
          shreg_d   = LSB_FIRST ? (shreg_q >> 1) : (shreg_q << 1);
          bit_idx_d = bit_idx_q + IDX_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign out_bit    = LSB_FIRST ? shreg_q[0] : shreg_q[WIDTH-1];
  assign busy       = (state_q == ST_SHIFT);
  assign serial_out = busy ? out_bit : IDLE_LEVEL;
  assign load_ready = (state_q == ST_IDLE) || last;
  assign bit_idx    = bit_idx_q;
  assign done       = done_q;

endmodule

// File: tb/tb_piso_serializer.sv
// Bench for piso_serializer: directed frame scenarios on MSB-first and LSB-first
// instances, plus a randomized run checked against a send-order bit model.
module tb_piso_serializer;

  localparam int W = 4;

  logic         clk;
  logic         rst_n;
  logic         load_valid, shift_en;
  logic [W-1:0] parallel_in;
  logic         load_ready, serial_out, busy, done;
  logic [1:0]   bit_idx;

  logic         load_valid2, shift_en2;
  logic [W-1:0] parallel_in2;
  logic         load_ready2, serial_out2, busy2, done2;
  logic [1:0]   bit_idx2;

  int n_checks = 0;
  int n_fail   = 0;

  piso_serializer #(.WIDTH(W), .LSB_FIRST(1'b0), .IDLE_LEVEL(1'b0)) dut (
    .clk(clk), .rst_n(rst_n), .load_valid(load_valid), .load_ready(load_ready),
    .parallel_in(parallel_in), .shift_en(shift_en), .serial_out(serial_out),
    .busy(busy), .bit_idx(bit_idx), .done(done)
  );

  piso_serializer #(.WIDTH(W), .LSB_FIRST(1'b1), .IDLE_LEVEL(1'b1)) dut2 (
    .clk(clk), .rst_n(rst_n), .load_valid(load_valid2), .load_ready(load_ready2),
    .parallel_in(parallel_in2), .shift_en(shift_en2), .serial_out(serial_out2),
    .busy(busy2), .bit_idx(bit_idx2), .done(done2)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference model: current frame as a list of bits in send order.
  logic       m_busy;
  logic       m_done;
  logic [0:W-1] m_bits;
  int         m_pos;

  task automatic model_load(input logic [W-1:0] d);
    for (int k = 0; k < W; k++) m_bits[k] = d[W-1-k];
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #3;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", done); end
    n_checks++; if (serial_out !== 1'b0) begin n_fail++; $display("FAIL reset_serial: got %b want 0", serial_out); end
    n_checks++; if (bit_idx !== 2'd0) begin n_fail++; $display("FAIL reset_bit_idx: got %0d want 0", bit_idx); end
    n_checks++; if (load_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", load_ready); end
    n_checks++; if (serial_out2 !== 1'b1) begin n_fail++; $display("FAIL reset_serial_idle_high: got %b want 1", serial_out2); end
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single_frame();
    logic [0:3] exp_b;
    exp_b = 4'b1010;
    load_valid = 1'b1; parallel_in = 4'b1010; shift_en = 1'b1;
    @(negedge clk);
    n_checks++; if (load_ready !== 1'b1) begin n_fail++; $display("FAIL single_ready_idle: got %b want 1", load_ready); end
    tick();
    load_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_checks++; if (serial_out !== exp_b[i]) begin n_fail++; $display("FAIL single_bit%0d: got %b want %b", i, serial_out, exp_b[i]); end
      n_checks++; if (bit_idx !== 2'(i)) begin n_fail++; $display("FAIL single_idx%0d: got %0d want %0d", i, bit_idx, i); end
      n_checks++; if (busy !== 1'b1 || done !== 1'b0) begin n_fail++; $display("FAIL single_status%0d: busy %b done %b want 1 0", i, busy, done); end
      tick();
    end
    @(negedge clk);
    n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL single_done: got %b want 1", done); end
    n_checks++; if (busy !== 1'b0 || serial_out !== 1'b0) begin n_fail++; $display("FAIL single_idle: busy %b serial %b want 0 0", busy, serial_out); end
    tick();
    @(negedge clk);
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL single_done_once: got %b want 0", done); end
    tick();
  endtask

  task automatic test_back_to_back();
    logic [0:7] exp_b;
    int n_done;
    exp_b = 8'b1010_1111;
    n_done = 0;
    load_valid = 1'b1; parallel_in = 4'b1010; shift_en = 1'b1;
    tick();
    parallel_in = 4'b1111;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (done === 1'b1) n_done++;
      n_checks++; if (serial_out !== exp_b[i] || busy !== 1'b1) begin n_fail++; $display("FAIL b2b_bit%0d: got %b busy %b want %b busy 1", i, serial_out, busy, exp_b[i]); end
      n_checks++; if (load_ready !== (i == 3 || i == 7)) begin n_fail++; $display("FAIL b2b_ready%0d: got %b want %b", i, load_ready, (i == 3 || i == 7)); end
      tick();
      if (i == 3) load_valid = 1'b0;
    end
    @(negedge clk);
    if (done === 1'b1) n_done++;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL b2b_end_busy: got %b want 0", busy); end
    n_checks++; if (n_done != 2) begin n_fail++; $display("FAIL b2b_done_count: got %0d want 2", n_done); end
    tick();
  endtask

  task automatic test_shift_gating();
    logic [0:3] exp_b;
    exp_b = 4'b1100;
    load_valid = 1'b1; parallel_in = 4'b1100; shift_en = 1'b0;
    tick();
    load_valid = 1'b0;
    for (int c = 0; c < 8; c++) begin
      shift_en = (c % 2 == 1);
      @(negedge clk);
      n_checks++; if (serial_out !== exp_b[c/2]) begin n_fail++; $display("FAIL gate_bit_c%0d: got %b want %b", c, serial_out, exp_b[c/2]); end
      n_checks++; if (bit_idx !== 2'(c/2)) begin n_fail++; $display("FAIL gate_idx_c%0d: got %0d want %0d", c, bit_idx, c/2); end
      tick();
    end
    shift_en = 1'b0;
    @(negedge clk);
    n_checks++; if (done !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL gate_done: done %b busy %b want 1 0", done, busy); end
    tick();
  endtask

  task automatic test_lsb_first_idle_high();
    logic [0:3] exp_b;
    exp_b = 4'b0001;
    load_valid2 = 1'b1; parallel_in2 = 4'b1000; shift_en2 = 1'b1;
    @(negedge clk);
    n_checks++; if (serial_out2 !== 1'b1 || load_ready2 !== 1'b1) begin n_fail++; $display("FAIL lsb_idle: serial %b ready %b want 1 1", serial_out2, load_ready2); end
    tick();
    load_valid2 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_checks++; if (serial_out2 !== exp_b[i] || busy2 !== 1'b1) begin n_fail++; $display("FAIL lsb_bit%0d: got %b busy %b want %b busy 1", i, serial_out2, busy2, exp_b[i]); end
      tick();
    end
    @(negedge clk);
    n_checks++; if (serial_out2 !== 1'b1 || done2 !== 1'b1 || busy2 !== 1'b0) begin n_fail++; $display("FAIL lsb_end: serial %b done %b busy %b want 1 1 0", serial_out2, done2, busy2); end
    shift_en2 = 1'b0;
    tick();
  endtask

  task automatic test_async_reset();
    logic [0:1] exp_b;
    exp_b = 2'b10;
    load_valid = 1'b1; parallel_in = 4'b1010; shift_en = 1'b1;
    tick();
    load_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      n_checks++; if (serial_out !== exp_b[i]) begin n_fail++; $display("FAIL arst_bit%0d: got %b want %b", i, serial_out, exp_b[i]); end
      tick();
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++; if (busy !== 1'b0 || serial_out !== 1'b0) begin n_fail++; $display("FAIL arst_now: busy %b serial %b want 0 0", busy, serial_out); end
    n_checks++; if (bit_idx !== 2'd0 || done !== 1'b0) begin n_fail++; $display("FAIL arst_idx_done: idx %0d done %b want 0 0", bit_idx, done); end
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_checks++; if (done !== 1'b0 || busy !== 1'b0 || load_ready !== 1'b1) begin n_fail++; $display("FAIL arst_after%0d: done %b busy %b ready %b want 0 0 1", i, done, busy, load_ready); end
      tick();
    end
  endtask

  task automatic test_load_while_busy();
    logic [0:7] exp_b;
    exp_b = 8'b1010_0110;
    load_valid = 1'b1; parallel_in = 4'b1010; shift_en = 1'b1;
    tick();
    load_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (i == 1) begin load_valid = 1'b1; parallel_in = 4'b0110; end
      @(negedge clk);
      n_checks++; if (serial_out !== exp_b[i] || busy !== 1'b1) begin n_fail++; $display("FAIL lwb_bit%0d: got %b busy %b want %b busy 1", i, serial_out, busy, exp_b[i]); end
      n_checks++; if (load_ready !== (i == 3 || i == 7)) begin n_fail++; $display("FAIL lwb_ready%0d: got %b want %b", i, load_ready, (i == 3 || i == 7)); end
      tick();
      if (i == 3) load_valid = 1'b0;
    end
    shift_en = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_random();
    logic exp_ser, exp_ready, acc, last, hold;
    m_busy = 1'b0; m_done = 1'b0; m_pos = 0; hold = 1'b0;
    for (int c = 0; c < 600; c++) begin
      if (!hold) begin
        load_valid  = ($urandom_range(0, 2) != 0);
        parallel_in = W'($urandom);
      end
      shift_en = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      exp_ser   = m_busy ? m_bits[m_pos] : 1'b0;
      exp_ready = !m_busy || (m_pos == W-1 && shift_en);
      n_checks++; if (serial_out !== exp_ser) begin n_fail++; $display("FAIL rnd_serial c%0d: got %b want %b", c, serial_out, exp_ser); end
      n_checks++; if (busy !== m_busy) begin n_fail++; $display("FAIL rnd_busy c%0d: got %b want %b", c, busy, m_busy); end
      n_checks++; if (load_ready !== exp_ready) begin n_fail++; $display("FAIL rnd_ready c%0d: got %b want %b", c, load_ready, exp_ready); end
      n_checks++; if (done !== m_done) begin n_fail++; $display("FAIL rnd_done c%0d: got %b want %b", c, done, m_done); end
      if (m_busy) begin
        n_checks++; if (bit_idx !== 2'(m_pos)) begin n_fail++; $display("FAIL rnd_idx c%0d: got %0d want %0d", c, bit_idx, m_pos); end
      end
      acc  = load_valid && exp_ready;
      last = m_busy && m_pos == W-1 && shift_en;
      hold = load_valid && !acc;
      @(posedge clk);
      m_done = last;
      if (acc) begin
        model_load(parallel_in);
        m_pos  = 0;
        m_busy = 1'b1;
      end else if (last) begin
        m_busy = 1'b0;
      end else if (m_busy && shift_en) begin
        m_pos++;
      end
      #1;
    end
    load_valid = 1'b0;
    shift_en   = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    load_valid = 1'b0; shift_en = 1'b0; parallel_in = '0;
    load_valid2 = 1'b0; shift_en2 = 1'b0; parallel_in2 = '0;
    m_busy = 1'b0; m_done = 1'b0; m_pos = 0; m_bits = '0;
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_shift_gating();
    test_lsb_first_idle_high();
    test_async_reset();
    test_load_while_busy();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
